// File: rtl/mul23_recombine.sv
// mul23_recombine: rebuilds the dividend x = 23*q + r from the quotient and
// remainder of a divide-by-23 datapath. The work is done one byte per cycle,
// with a small carry chain running through the bytes.
//   IDLE -> accept an operand pair (in_ready = 1)
//   CALC -> eight byte cycles (i = 0..7), then one cycle that records ovf
//   DONE -> hold the result until out_ready (out_valid = 1)
// Latency from the accepting edge to out_valid is always 9 cycles.
// Optional feature macro: MUL23_REM_CHECK_EN. When it is defined, rem_err
// flags results whose r was 23 or more. When it is undefined, rem_err is
// tied to 0.
module mul23_recombine (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] q,
  input  logic [4:0]  r,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] x,
  output logic        ovf,
  output logic        rem_err
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t      state;
  state_t      state_next;
  logic [63:0] q_hold;
  logic [4:0]  carry;
  logic [3:0]  idx;      // 0..7 are byte cycles; 8 is the closing cycle that records ovf
  logic [7:0]  q_byte;
  logic [12:0] s;
  logic        take;

  assign take      = in_valid && (state == IDLE);
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  // One byte-slice multiply-accumulate. 23*255 + 31 = 5896 fits in 13 bits.
  always_comb begin
    q_byte = q_hold[{idx[2:0], 3'b000} +: 8];
    s      = 13'(q_byte) * 13'd23 + 13'(carry);
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (in_valid)  state_next = CALC;
      CALC:    if (idx[3])    state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default:                state_next = IDLE;
    endcase
  end

  // Datapath: capture the operands on a transfer, then walk the bytes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_hold <= '0;
      carry  <= '0;
      idx    <= '0;
      x      <= '0;
      ovf    <= 1'b0;
    end else if (take) begin
      q_hold <= q;
      carry  <= r;
      idx    <= '0;
    end else if (state == CALC) begin
      if (idx[3]) begin
        ovf <= (carry != 5'd0);
      end else begin
        x[{idx[2:0], 3'b000} +: 8] <= s[7:0];
        carry <= s[12:8];
        idx   <= idx + 4'd1;
      end
    end
  end

`ifdef MUL23_REM_CHECK_EN
  // Remainder range flag, sampled with the operands and held with the result
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       rem_err <= 1'b0;
    else if (take) rem_err <= (r >= 5'd23);
  end
`else
  assign rem_err = 1'b0;
`endif

endmodule

// File: tb/tb_mul23_recombine.sv
// tb_mul23_recombine: a scoreboard-based bench for mul23_recombine. The
// stimulus process pushes the expected result from a wide-arithmetic model.
// The monitor pops and compares that result whenever the DUT hands over an
// output.
module tb_mul23_recombine;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] q;
  logic [4:0]  r;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] x;
  logic        ovf;
  logic        rem_err;

  typedef struct packed {
    logic [63:0] x;
    logic        ovf;
    logic        rem_err;
  } exp_t;

  exp_t exp_q[$];
  int   compared   = 0;
  int   mismatched = 0;

  always #5 clk = ~clk;

  mul23_recombine dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .q         (q),
    .r         (r),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .x         (x),
    .ovf       (ovf),
    .rem_err   (rem_err)
  );

  // Reference: plain 128-bit arithmetic on the whole value
  function automatic exp_t model(input logic [63:0] qv, input logic [4:0] rv);
    logic [127:0] full;
    exp_t e;
    full = {64'd0, qv} * 128'd23 + {123'd0, rv};
    e.x   = full[63:0];
    e.ovf = (full[127:64] != 64'd0);
`ifdef MUL23_REM_CHECK_EN
    e.rem_err = (rv >= 5'd23);
`else
    e.rem_err = 1'b0;
`endif
    return e;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s: got 0x%016h, required 0x%016h", name, act, req);
    end
  endtask

  // Monitor: compares results on handover and checks stability under backpressure
  logic [65:0] held;
  logic        stalled = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (!rst && out_valid) begin
      if (stalled) check("stall_stable", {62'd0, held[65:64] ^ {ovf, rem_err}} | {2'd0, held[63:0] ^ x}, 66'd0);
      if (out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_out", 64'd1, 64'd0);
        end else begin
          e = exp_q.pop_front();
          check("x", x, e.x);
          check("ovf", {63'd0, ovf}, {63'd0, e.ovf});
          check("rem_err", {63'd0, rem_err}, {63'd0, e.rem_err});
          $display("result q->x=0x%016h ovf=%0b rem_err=%0b", x, ovf, rem_err);
        end
        stalled = 1'b0;
      end else begin
        held    = {ovf, rem_err, x};
        stalled = 1'b1;
      end
    end else begin
      stalled = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Send one pair, check latency, then stall for 'hold' cycles with junk inputs
  task automatic send(input logic [63:0] qv, input logic [4:0] rv, input int hold);
    int cyc;
    int guard;
    guard = 0;
    while (!in_ready && guard < 50) begin
      tick();
      guard++;
    end
    check("in_ready_wait", {63'd0, in_ready}, 64'd1);
    in_valid = 1'b1;
    q = qv;
    r = rv;
    exp_q.push_back(model(qv, rv));
    $display("send q=0x%016h r=%0d hold=%0d", qv, rv, hold);
    tick();
    in_valid = 1'b0;
    q = 64'($urandom) << 32 | 64'($urandom);
    r = 5'($urandom);
    cyc = 0;
    while (!out_valid && cyc < 40) begin
      tick();
      cyc++;
    end
    check("latency", 64'(cyc), 64'd9);
    for (int k = 0; k < hold; k++) begin
      in_valid = 1'b1;
      q = 64'($urandom);
      r = 5'($urandom);
      check("in_ready_done", {63'd0, in_ready}, 64'd0);
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("back_idle", {62'd0, in_ready, out_valid}, 64'd2);
  endtask

  initial begin
    logic [63:0] qr;
    int guard;
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    q = '0;
    r = '0;
    #13;
    check("rst_in_ready", {63'd0, in_ready}, 64'd1);
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_x", x, 64'd0);
    check("rst_flags", {62'd0, ovf, rem_err}, 64'd0);
    tick();
    rst = 1'b0;

    send(64'd0, 5'd0, 0);
    send(64'd1000, 5'd5, 1);
    send(64'd1, 5'd22, 0);
    send(64'hFFFF_FFFF_FFFF_FFFF, 5'd0, 5);
    send(64'h0B21_642C_8590_B217, 5'd0, 2);
    send(64'd0, 5'd23, 0);
    send(64'd7, 5'd3, 0);

    // Reset during CALC: the operation must vanish
    in_valid = 1'b1;
    q = 64'h1234_5678_9ABC_DEF0;
    r = 5'd9;
    tick();
    in_valid = 1'b0;
    repeat (4) tick();
    rst = 1'b1;
    #1;
    check("midrst_in_ready", {63'd0, in_ready}, 64'd1);
    check("midrst_x", x, 64'd0);
    tick();
    rst = 1'b0;
    for (int k = 0; k < 12; k++) begin
      check("midrst_no_out", {63'd0, out_valid}, 64'd0);
      tick();
    end
    send(64'd2, 5'd1, 0);

    for (int n = 0; n < 30; n++) begin
      qr = {32'($urandom), 32'($urandom)};
      if (n % 5 == 0) qr = 64'hFFFF_FFFF_FFFF_FFFF - 64'($urandom_range(0, 3));
      if (n % 7 == 0) qr = 64'h0B21_642C_8590_B215 + 64'($urandom_range(0, 3));
      send(qr, 5'($urandom_range(0, 31)), $urandom_range(0, 3));
    end

    guard = 0;
    while (exp_q.size() != 0 && guard < 100) begin
      tick();
      guard++;
    end
    check("drain", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/mul23_recombine.md
MUL23_RECOMBINE -- requirements
Module: mul23_recombine

Interface
REQ-001 The block SHALL have these ports: clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-002 The block SHALL have these ports: rst, input, 1 bit, reset; asynchronous and active-high.
REQ-003 The block SHALL have these ports: in_valid, input, 1 bit, an operand pair is presented.
REQ-004 The block SHALL have these ports: in_ready, output, 1 bit, the block can accept an operand pair.
REQ-005 The block SHALL have these ports: q, input, 64 bits, the quotient from the divide-by-23 datapath.
REQ-006 The block SHALL have these ports: r, input, 5 bits, the remainder from the divide-by-23 datapath.
REQ-007 The block SHALL have these ports: out_valid, output, 1 bit, the result is presented.
REQ-008 The block SHALL have these ports: out_ready, input, 1 bit, the consumer accepts the result.
REQ-009 The block SHALL have these ports: x, output, 64 bits, the reconstructed dividend, equal to 23*q + r modulo 2^64.
REQ-010 The block SHALL have these ports: ovf, output, 1 bit, 23*q + r is 2^64 or greater.
REQ-011 The block SHALL have these ports: rem_err, output, 1 bit, r is 23 or greater (see Configuration).

Function
REQ-012 The block SHALL use three states: IDLE, CALC and DONE.
REQ-013 in_ready SHALL be 1 only in IDLE.
REQ-014 out_valid SHALL be 1 only in DONE.
REQ-015 A transfer SHALL occur on a rising edge where in_valid and in_ready are both 1.
REQ-016 On a transfer, the block SHALL register q and r, clear the byte index to 0, set carry = r and move to CALC.
REQ-017 Each CALC cycle, the block SHALL compute s = 23*q[8i+7:8i] + carry (13 bits), write x[8i+7:8i] = s[7:0], set carry = s[12:8] and increment i.
REQ-018 carry SHALL stay below 32 for every r below 32: 5865 + 31 < 8192, so s[12:8] is at most 23.
REQ-019 After the CALC cycle with i = 7, the block SHALL set ovf = (carry != 0) and move to DONE.
REQ-020 Latency SHALL be fixed at 9 cycles: a transfer at edge N gives out_valid = 1 after edge N+9, independent of data.
REQ-021 In DONE, x, ovf and rem_err SHALL stay stable while out_ready = 0.
REQ-022 A DONE cycle with out_ready = 1 SHALL return the block to IDLE; in_ready = 1 on the next cycle, so there is no same-cycle pass-through.
REQ-023 in_valid SHALL be ignored outside IDLE.
REQ-024 q and r SHALL be sampled only on a transfer; later changes to q and r SHALL have no effect.
REQ-025 x, ovf and rem_err SHALL be driven from registers; there is no combinational path from input to output.

Reset
REQ-026 While rst = 1, the block SHALL immediately force state to IDLE, i, carry and x to 0, ovf, rem_err and out_valid to 0, and in_ready to 1.
REQ-027 A reset asserted mid-CALC or in DONE SHALL discard the operation with no result emitted.
REQ-028 The first transfer SHALL be possible on the first rising edge after rst deasserts.

Configuration
REQ-029 The feature is controlled by the macro MUL23_REM_CHECK_EN.
REQ-030 With MUL23_REM_CHECK_EN defined, a transfer with r >= 23 SHALL set rem_err = 1 for that result.
REQ-031 With MUL23_REM_CHECK_EN defined, the computation SHALL still proceed using the raw r value.
REQ-032 With MUL23_REM_CHECK_EN defined, rem_err SHALL clear on the next transfer with a valid r.
REQ-033 Without MUL23_REM_CHECK_EN, rem_err SHALL be tied to 0, no comparison logic is built, and r is used unchecked.

Verification
REQ-034 Zero operands: q = 0, r = 0 -> x = 0, ovf = 0, out_valid after exactly 9 cycles.
REQ-035 Small values: q = 1000, r = 5 -> x = 0x00000000000059DD (23005), ovf = 0; then q = 1, r = 22 -> x = 45.
REQ-036 Wrap-around: q = 0xFFFFFFFFFFFFFFFF, r = 0 -> x = 0xFFFFFFFFFFFFFFE9, ovf = 1; also q = 0x0B21642C8590B217, r = 0 -> ovf = 1.
REQ-037 Backpressure: hold out_ready = 0 for 5 cycles in DONE -> x and ovf stable and in_ready = 0; a changed in_valid/q is ignored; release -> IDLE next cycle.
REQ-038 Reset mid-CALC: assert rst at CALC cycle 4 -> out_valid never rises for that operation; the next transfer q = 2, r = 1 -> x = 47.
REQ-039 Remainder check: with MUL23_REM_CHECK_EN defined, q = 0, r = 23 -> x = 23, rem_err = 1; without the macro, rem_err = 0.
